// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler: serialises branch-resolution updates from two decode
// slots into the single write port of the branch target buffer. Updates are
// queued in program order, new entries are allocated round-robin, and the
// global-history register is shifted on every accepted resolution.
// Optional statistics counters are compiled in with BTB_SCHED_STATS_EN.
module btb_update_scheduler #(
    parameter int ENTRIES = 128,
    parameter int IDXW    = 7,
    parameter int QDEPTH  = 4,
    parameter int GHRW    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       lookup_busy,
    input  logic                       upd0_valid,
    input  logic [31:0]                upd0_pc,
    input  logic [31:0]                upd0_target,
    input  logic                       upd0_taken,
    input  logic                       upd0_hit,
    input  logic [IDXW-1:0]            upd0_idx,
    input  logic                       upd1_valid,
    input  logic [31:0]                upd1_pc,
    input  logic [31:0]                upd1_target,
    input  logic                       upd1_taken,
    input  logic                       upd1_hit,
    input  logic [IDXW-1:0]            upd1_idx,
    output logic                       upd_ready,
    output logic                       btb_we,
    output logic [IDXW-1:0]            btb_widx,
    output logic [31:0]                btb_wpc,
    output logic [31:0]                btb_wtarget,
    output logic                       btb_wtaken,
    output logic                       btb_walloc,
    output logic [GHRW-1:0]            ghr,
    output logic [$clog2(QDEPTH):0]    q_count,
    output logic [15:0]                stat_writes,
    output logic [15:0]                stat_stalls
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [31:0]     pc;
        logic [31:0]     target;
        logic            taken;
        logic            alloc;
    } entry_t;

    entry_t          fifo [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [IDXW-1:0] alloc_ptr;

    logic            empty;
    logic            acc0, acc1;
    logic            enq0, enq1;
    logic            al0, al1;
    entry_t          ent0, ent1;
    entry_t          head;
    logic [IDXW-1:0] alloc_next;
    logic [GHRW-1:0] ghr_next;
    logic [CW-1:0]   count_next;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] p);
        return (p == IDXW'(ENTRIES - 1)) ? '0 : p + IDXW'(1);
    endfunction

    assign empty     = (q_count == '0);
    // Room for two is required so both slots can always be accepted together.
    assign upd_ready = !flush && (q_count <= CW'(QDEPTH - 2));
    assign btb_we    = !empty && !lookup_busy && !flush;

    assign head        = fifo[rd_ptr];
    assign btb_widx    = empty ? '0 : head.idx;
    assign btb_wpc     = empty ? '0 : head.pc;
    assign btb_wtarget = empty ? '0 : head.target;
    assign btb_wtaken  = empty ? 1'b0 : head.taken;
    assign btb_walloc  = empty ? 1'b0 : head.alloc;

    // Classify each slot, pick its BTB index and compute next pointer/history values.
    always_comb begin
        acc0 = upd0_valid && upd_ready;
        acc1 = upd1_valid && upd_ready;
        al0  = acc0 && !upd0_hit && upd0_taken;
        al1  = acc1 && !upd1_hit && upd1_taken;
        enq0 = acc0 && (upd0_hit || upd0_taken);
        enq1 = acc1 && (upd1_hit || upd1_taken);

        ent0.idx    = upd0_hit ? upd0_idx : alloc_ptr;
        ent0.pc     = upd0_pc;
        ent0.target = upd0_target;
        ent0.taken  = upd0_taken;
        ent0.alloc  = !upd0_hit;

        ent1.idx    = upd1_hit ? upd1_idx : (al0 ? next_idx(alloc_ptr) : alloc_ptr);
        ent1.pc     = upd1_pc;
        ent1.target = upd1_target;
        ent1.taken  = upd1_taken;
        ent1.alloc  = !upd1_hit;

        alloc_next = alloc_ptr;
        if (al0 && al1)
            alloc_next = next_idx(next_idx(alloc_ptr));
        else if (al0 || al1)
            alloc_next = next_idx(alloc_ptr);

        ghr_next = ghr;
        if (acc0 && acc1)
            ghr_next = GHRW'({ghr, upd0_taken, upd1_taken});
        else if (acc0)
            ghr_next = GHRW'({ghr, upd0_taken});
        else if (acc1)
            ghr_next = GHRW'({ghr, upd1_taken});

        count_next = q_count + CW'(enq0) + CW'(enq1) - CW'(btb_we);
    end

    // Queue storage: slot 0 lands first, slot 1 directly behind it.
    always_ff @(posedge clk) begin
        if (enq0)
            fifo[wr_ptr] <= ent0;
        if (enq1)
            fifo[wr_ptr + PW'(enq0)] <= ent1;
    end

    // Queue pointers, occupancy, allocation pointer and global history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            q_count   <= '0;
            alloc_ptr <= '0;
            ghr       <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (btb_we)
                rd_ptr <= rd_ptr + PW'(1);
            wr_ptr    <= wr_ptr + PW'(enq0) + PW'(enq1);
            q_count   <= count_next;
            alloc_ptr <= alloc_next;
            ghr       <= ghr_next;
        end
    end

`ifdef BTB_SCHED_STATS_EN
    // Saturating write/stall counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            if (btb_we && stat_writes != 16'hFFFF)
                stat_writes <= stat_writes + 16'd1;
            if (!empty && lookup_busy && stat_stalls != 16'hFFFF)
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`else
    assign stat_writes = '0;
    assign stat_stalls = '0;
`endif

    slot0_idx_range: assert property (@(posedge clk) disable iff (reset)
        (upd0_valid && upd0_hit) |-> (32'(upd0_idx) < ENTRIES));
    slot1_idx_range: assert property (@(posedge clk) disable iff (reset)
        (upd1_valid && upd1_hit) |-> (32'(upd1_idx) < ENTRIES));

endmodule

// File: tb/tb_btb_update_scheduler.sv
// tb_btb_update_scheduler: directed plus random stimulus for btb_update_scheduler,
// compared cycle by cycle against a queue-based reference model.
module tb_btb_update_scheduler;

    localparam int ENTRIES = 128;
    localparam int IDXW    = 7;
    localparam int QDEPTH  = 4;
    localparam int GHRW    = 2;

    logic        clk = 1'b0;
    logic        reset, flush, lookup_busy;
    logic        upd0_valid, upd0_taken, upd0_hit;
    logic [31:0] upd0_pc, upd0_target;
    logic [6:0]  upd0_idx;
    logic        upd1_valid, upd1_taken, upd1_hit;
    logic [31:0] upd1_pc, upd1_target;
    logic [6:0]  upd1_idx;
    logic        upd_ready, btb_we, btb_wtaken, btb_walloc;
    logic [6:0]  btb_widx;
    logic [31:0] btb_wpc, btb_wtarget;
    logic [1:0]  ghr;
    logic [2:0]  q_count;
    logic [15:0] stat_writes, stat_stalls;

    always #5 clk = ~clk;

    btb_update_scheduler #(.ENTRIES(ENTRIES), .IDXW(IDXW), .QDEPTH(QDEPTH), .GHRW(GHRW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .lookup_busy(lookup_busy),
        .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_target(upd0_target),
        .upd0_taken(upd0_taken), .upd0_hit(upd0_hit), .upd0_idx(upd0_idx),
        .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_target(upd1_target),
        .upd1_taken(upd1_taken), .upd1_hit(upd1_hit), .upd1_idx(upd1_idx),
        .upd_ready(upd_ready), .btb_we(btb_we), .btb_widx(btb_widx), .btb_wpc(btb_wpc),
        .btb_wtarget(btb_wtarget), .btb_wtaken(btb_wtaken), .btb_walloc(btb_walloc),
        .ghr(ghr), .q_count(q_count), .stat_writes(stat_writes), .stat_stalls(stat_stalls)
    );

    typedef struct {
        logic [6:0]  idx;
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        alloc;
    } wrec_t;

    typedef struct {
        logic        v0, tk0, h0;
        logic [31:0] pc0, tg0;
        logic [6:0]  i0;
        logic        v1, tk1, h1;
        logic [31:0] pc1, tg1;
        logic [6:0]  i1;
        logic        fl, busy;
    } stim_t;

    wrec_t mq[$];
    int    m_alloc;
    int    m_ghr;
    int    m_writes, m_stalls;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_alloc  = 0;
        m_ghr    = 0;
        m_writes = 0;
        m_stalls = 0;
    endtask

    task automatic checkOutput();
        bit exp_ready;
        bit exp_we;
        exp_ready = !flush && (QDEPTH - mq.size() >= 2);
        exp_we    = (mq.size() != 0) && !lookup_busy && !flush;
        check("upd_ready", {31'd0, upd_ready}, {31'd0, exp_ready});
        check("btb_we", {31'd0, btb_we}, {31'd0, exp_we});
        check("q_count", {29'd0, q_count}, mq.size());
        check("ghr", {30'd0, ghr}, m_ghr);
        if (exp_we && btb_we) begin
            check("widx", {25'd0, btb_widx}, {25'd0, mq[0].idx});
            check("wpc", btb_wpc, mq[0].pc);
            check("wtarget", btb_wtarget, mq[0].target);
            check("wtaken", {31'd0, btb_wtaken}, {31'd0, mq[0].taken});
            check("walloc", {31'd0, btb_walloc}, {31'd0, mq[0].alloc});
        end
        check("stat_writes", {16'd0, stat_writes}, m_writes);
        check("stat_stalls", {16'd0, stat_stalls}, m_stalls);
    endtask

    task automatic acceptSlot(input logic v, input logic [31:0] pc, input logic [31:0] tg,
                              input logic tk, input logic h, input logic [6:0] idx);
        wrec_t r;
        if (!v) return;
        m_ghr = ((m_ghr << 1) | int'(tk)) % (1 << GHRW);
        r.pc = pc;
        r.target = tg;
        r.taken = tk;
        if (h) begin
            r.idx = idx;
            r.alloc = 1'b0;
            mq.push_back(r);
        end else if (tk) begin
            r.idx = 7'(m_alloc);
            r.alloc = 1'b1;
            mq.push_back(r);
            m_alloc = (m_alloc + 1) % ENTRIES;
        end
    endtask

    task automatic modelStep(input stim_t s);
        bit rdy;
        bit we;
        rdy = !s.fl && (QDEPTH - mq.size() >= 2);
        we  = (mq.size() != 0) && !s.busy && !s.fl;
`ifdef BTB_SCHED_STATS_EN
        if (we && m_writes < 65535) m_writes++;
        if (mq.size() != 0 && s.busy && m_stalls < 65535) m_stalls++;
`endif
        if (s.fl) begin
            mq.delete();
        end else begin
            if (we) void'(mq.pop_front());
            if (rdy) begin
                acceptSlot(s.v0, s.pc0, s.tg0, s.tk0, s.h0, s.i0);
                acceptSlot(s.v1, s.pc1, s.tg1, s.tk1, s.h1, s.i1);
            end
        end
    endtask

    task automatic drive(input stim_t s);
        upd0_valid = s.v0; upd0_pc = s.pc0; upd0_target = s.tg0;
        upd0_taken = s.tk0; upd0_hit = s.h0; upd0_idx = s.i0;
        upd1_valid = s.v1; upd1_pc = s.pc1; upd1_target = s.tg1;
        upd1_taken = s.tk1; upd1_hit = s.h1; upd1_idx = s.i1;
        flush = s.fl; lookup_busy = s.busy;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        drive(s);
        #1;
        checkOutput();
        modelStep(s);
    endtask

    function automatic stim_t idle(input logic busy);
        stim_t s;
        s = '{default: '0};
        s.busy = busy;
        return s;
    endfunction

    function automatic stim_t rnd(input int busy_pct, input int flush_pct);
        stim_t s;
        s.v0 = ($urandom_range(0, 99) < 70);
        s.tk0 = 1'($urandom_range(0, 1));
        s.h0 = 1'($urandom_range(0, 1));
        s.pc0 = $urandom;
        s.tg0 = $urandom;
        s.i0 = 7'($urandom_range(0, ENTRIES - 1));
        s.v1 = ($urandom_range(0, 99) < 70);
        s.tk1 = 1'($urandom_range(0, 1));
        s.h1 = 1'($urandom_range(0, 1));
        s.pc1 = $urandom;
        s.tg1 = $urandom;
        s.i1 = 7'($urandom_range(0, ENTRIES - 1));
        s.busy = ($urandom_range(0, 99) < busy_pct);
        s.fl = ($urandom_range(0, 99) < flush_pct);
        return s;
    endfunction

    initial begin
        stim_t s;
        reset = 1'b1;
        drive(idle(1'b0));
        modelReset();
        #2;
        checkOutput();
        check("rst_ready", {31'd0, upd_ready}, 32'd1);
        check("rst_walloc", {31'd0, btb_walloc}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Allocation straight after reset
        s = idle(1'b0);
        s.v0 = 1'b1; s.pc0 = 32'h40; s.tg0 = 32'h80; s.tk0 = 1'b1;
        applyStimulus(s);
        applyStimulus(idle(1'b0));
        check("t1_we", {31'd0, btb_we}, 32'd1);
        check("t1_widx", {25'd0, btb_widx}, 32'd0);
        check("t1_wpc", btb_wpc, 32'h40);
        check("t1_walloc", {31'd0, btb_walloc}, 32'd1);
        check("t1_ghr", {30'd0, ghr}, 32'd1);
        applyStimulus(idle(1'b0));

        // Dual update: hit in slot 0, allocation in slot 1
        s = idle(1'b0);
        s.v0 = 1'b1; s.h0 = 1'b1; s.i0 = 7'd5; s.tk0 = 1'b0; s.pc0 = 32'h100; s.tg0 = 32'h200;
        s.v1 = 1'b1; s.h1 = 1'b0; s.tk1 = 1'b1; s.pc1 = 32'h104; s.tg1 = 32'h300;
        applyStimulus(s);
        applyStimulus(idle(1'b0));
        check("t2_widx0", {25'd0, btb_widx}, 32'd5);
        check("t2_wtaken0", {31'd0, btb_wtaken}, 32'd0);
        check("t2_ghr", {30'd0, ghr}, 32'd1);
        applyStimulus(idle(1'b0));
        check("t2_widx1", {25'd0, btb_widx}, 32'd1);
        check("t2_walloc1", {31'd0, btb_walloc}, 32'd1);
        applyStimulus(idle(1'b0));

        // Backpressure while the read port is busy
        for (int i = 0; i < 6; i++) begin
            s = rnd(100, 0);
            s.v0 = 1'b1; s.h0 = 1'b1; s.v1 = 1'b0;
            applyStimulus(s);
            if (i == 3) begin
                check("t3_qcount", {29'd0, q_count}, 32'd3);
                check("t3_ready", {31'd0, upd_ready}, 32'd0);
            end
        end
        for (int i = 0; i < 5; i++) applyStimulus(idle(1'b0));

        // Flush with two queued updates
        for (int i = 0; i < 2; i++) begin
            s = rnd(100, 0);
            s.v0 = 1'b1; s.h0 = 1'b1; s.v1 = 1'b0;
            applyStimulus(s);
        end
        s = rnd(0, 0);
        s.fl = 1'b1;
        applyStimulus(s);
        check("t5_flush_we", {31'd0, btb_we}, 32'd0);
        applyStimulus(idle(1'b0));
        check("t5_qcount", {29'd0, q_count}, 32'd0);
        applyStimulus(idle(1'b0));

        // Round-robin wrap: long run of dual allocations
        for (int i = 0; i < 150; i++) begin
            s = rnd(0, 0);
            s.v0 = 1'b1; s.h0 = 1'b0; s.tk0 = 1'b1;
            s.v1 = 1'b1; s.h1 = 1'b0; s.tk1 = 1'b1;
            applyStimulus(s);
        end
        for (int i = 0; i < 5; i++) applyStimulus(idle(1'b0));

        // Random traffic with stalls and occasional flushes
        for (int i = 0; i < 400; i++) applyStimulus(rnd(30, 5));

        // Reset in the middle of activity
        for (int i = 0; i < 3; i++) applyStimulus(rnd(80, 0));
        @(posedge clk);
        #2;
        drive(idle(1'b0));
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) applyStimulus(rnd(30, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_update_scheduler.md
Name: btb_update_scheduler

Overview:
- Sequences all writes into the single-write-port branch target buffer of the global branch predictor.
- Accepts branch-resolution updates from both superscalar decode slots (slot 0 older, slot 1 younger) and queues them in program order.
- Allocates BTB entries round-robin and maintains the global-history register.
- Drains one write per cycle into the BTB; stalls while the BTB read port is busy with a fetch lookup.

Parameters:
- ENTRIES, 128, number of BTB entries.
- IDXW, 7, BTB index width; equals clog2(ENTRIES).
- QDEPTH, 4, update FIFO depth; power of two, minimum 2.
- GHRW, 2, global-history width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all queued updates.
- lookup_busy  in  1  BTB read port in use this cycle; suppresses the write.
- upd0_valid  in  1  slot-0 branch resolved.
- upd0_pc  in  32  slot-0 branch PC.
- upd0_target  in  32  slot-0 resolved target.
- upd0_taken  in  1  slot-0 outcome.
- upd0_hit  in  1  slot-0 PC was found in the BTB.
- upd0_idx  in  IDXW  slot-0 hit index; valid only when upd0_hit=1.
- upd1_valid, upd1_pc, upd1_target, upd1_taken, upd1_hit, upd1_idx  in  same widths as slot 0  slot-1 equivalents.
- upd_ready  out  1  both slots may present an update this cycle.
- btb_we  out  1  BTB write strobe.
- btb_widx  out  IDXW  write index.
- btb_wpc  out  32  tag (branch PC).
- btb_wtarget  out  32  target.
- btb_wtaken  out  1  counter direction: 1 = strengthen taken, 0 = weaken.
- btb_walloc  out  1  new entry; BTB clears all counters before applying the direction.
- ghr  out  GHRW  global history, newest outcome in bit 0.
- q_count  out  clog2(QDEPTH)+1  occupancy.
- stat_writes  out  16  see Optional Feature.
- stat_stalls  out  16  see Optional Feature.

Behaviour:
- Reset values: FIFO empty, q_count=0, alloc_ptr=0, ghr=0, btb_we=0, upd_ready=1. All other outputs 0.
- upd_ready = !flush && (QDEPTH - q_count >= 2). It depends only on registered state and flush, never on the valids.
- Accept: updK_valid && upd_ready. Requests with upd_ready=0 are ignored; the producer holds them.
- Classification at accept:
  - hit=1: enqueue with idx=updK_idx, alloc=0, taken=updK_taken.
  - hit=0, taken=1: enqueue with idx=alloc_ptr, alloc=1.
  - hit=0, taken=0: not enqueued.
- Allocation order: slot 0 is enqueued before slot 1. When both allocate in the same cycle, slot 0 gets alloc_ptr and slot 1 gets alloc_ptr+1. The pointer wraps ENTRIES-1 -> 0.
- No duplicate-PC detection; identical allocating PCs receive two entries.
- GHR, on any accepted update:
  - one accept: ghr <= {ghr[GHRW-2:0], t}.
  - both slots: ghr <= {ghr[GHRW-3:0], t0, t1}; for GHRW=2 this is {t0, t1}.
  - Non-enqueued not-taken updates still shift the GHR.
- Drain:
  - btb_we = !empty && !lookup_busy && !flush.
  - btb_w* are driven combinationally from the FIFO head; head pops at the posedge when btb_we=1.
  - Latency: accepted at edge N, earliest btb_we in cycle N+1.
  - lookup_busy=1 holds the head stable.
- Simultaneous enqueue of 0..2 and dequeue of 0..1 in one cycle: q_count updates by the net amount. The capacity check uses the registered q_count, so overflow is impossible.
- Flush: at the edge, FIFO empties, q_count=0, btb_we=0 during the flush cycle, updates in that cycle are ignored. alloc_ptr and ghr are unchanged.
- Reset mid-operation: immediate return to reset values; queued updates are lost.
- Asserting updK_hit=1 with an out-of-range idx is unsupported; an assertion fires in simulation.

Optional Feature:
- Macro BTB_SCHED_STATS_EN.
- Defined:
  - stat_writes increments on every btb_we.
  - stat_stalls increments on each cycle with !empty && lookup_busy.
  - Both are 16-bit, saturate at 0xFFFF, reset to 0, and are unaffected by flush.
- Undefined: no counter registers; stat_writes and stat_stalls are tied to 0.

Test Plan:
- Post-reset alloc: slot0 pc=0x40, target=0x80, taken=1, hit=0 -> next cycle btb_we=1, widx=0, wpc=0x40, wtarget=0x80, walloc=1; ghr=2'b01.
- Dual update: slot0 hit=1 idx=5 taken=0 and slot1 hit=0 taken=1, same cycle -> writes in consecutive cycles: idx 5 (walloc=0, wtaken=0), then alloc_ptr (walloc=1); ghr=2'b01.
- Backpressure: lookup_busy=1 for 6 cycles while feeding 4 single updates -> q_count reaches 3, upd_ready=0 at q_count=3, no btb_we. After release, 3 writes drain in FIFO order.
- Wrap: 128 allocations -> 129th gets widx=0.
- Flush: flush with q_count=2 -> q_count=0, no further btb_we, ghr unchanged.
- Stats (macro on): 10 writes, 4 stall cycles -> stat_writes=10, stat_stalls=4. Macro off -> both read 0.
